// File: rtl/av2_recon_pkg.sv
// Shared types and helpers for the AV2 reconstruction adder: FSM states,
// legal block edge sizes and the size legality check.
package av2_recon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam int SIZE_W = 7;

    localparam logic [SIZE_W-1:0] SIZE_4  = 7'd4;
    localparam logic [SIZE_W-1:0] SIZE_8  = 7'd8;
    localparam logic [SIZE_W-1:0] SIZE_16 = 7'd16;
    localparam logic [SIZE_W-1:0] SIZE_32 = 7'd32;
    localparam logic [SIZE_W-1:0] SIZE_64 = 7'd64;

    localparam int CLIP_CNT_W = 13;

    function automatic logic size_legal(input logic [SIZE_W-1:0] s);
        return (s == SIZE_4) || (s == SIZE_8) || (s == SIZE_16) ||
               (s == SIZE_32) || (s == SIZE_64);
    endfunction

endpackage

// File: rtl/av2_clip_pixel.sv
// Combinational residual + prediction add with clipping to the pixel range;
// flags when the raw sum fell outside [0, 2^BIT_DEPTH-1].
module av2_clip_pixel #(
    parameter int BIT_DEPTH = 10
) (
    input  logic signed [15:0]          res,
    input  logic        [BIT_DEPTH-1:0] pred,
    output logic        [BIT_DEPTH-1:0] pix,
    output logic                        clipped
);

    localparam logic signed [17:0] PIX_MAX = $signed(18'((1 << BIT_DEPTH) - 1));

    logic signed [17:0] res_ext;
    logic signed [17:0] pred_ext;
    logic signed [17:0] sum;

    // 18 bits hold the full range of a 16-bit residual plus a 12-bit pixel.
    assign res_ext  = $signed({{2{res[15]}}, res});
    assign pred_ext = $signed({{(18 - BIT_DEPTH){1'b0}}, pred});
    assign sum      = res_ext + pred_ext;

    always_comb begin
        pix     = sum[BIT_DEPTH-1:0];
        clipped = 1'b0;
        if (sum[17]) begin
            pix     = '0;
            clipped = 1'b1;
        end else if (sum > PIX_MAX) begin
            pix     = '1;
            clipped = 1'b1;
        end
    end

endmodule

// File: rtl/av2_recon_add.sv
// AV2 reconstruction adder: joins residual and prediction streams, adds and
// clips each pair into a one-deep output register. Optional AV2_RECON_CLIP_CNT_EN
// adds a per-block clip_count output.
module av2_recon_add
    import av2_recon_pkg::*;
#(
    parameter int BIT_DEPTH    = 10,
    parameter int MAX_BLK_SIZE = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [6:0]           blk_width,
    input  logic [6:0]           blk_height,
    input  logic                 res_valid,
    output logic                 res_ready,
    input  logic signed [15:0]   res_data,
    input  logic                 pred_valid,
    output logic                 pred_ready,
    input  logic [BIT_DEPTH-1:0] pred_data,
    output logic                 rec_valid,
    input  logic                 rec_ready,
    output logic [BIT_DEPTH-1:0] rec_data,
    output logic                 rec_last,
    output logic                 busy,
    output logic                 done,
    output logic                 size_err
`ifdef AV2_RECON_CLIP_CNT_EN
    ,
    output logic [CLIP_CNT_W-1:0] clip_count
`endif
);

    localparam int CNT_W = $clog2(MAX_BLK_SIZE * MAX_BLK_SIZE);

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   term_q;
    logic [13:0]        area;
    logic               size_ok;
    logic               start_ok;
    logic               in_ready;
    logic               consume;
    logic               last_pair;
    logic [BIT_DEPTH-1:0] pix;
    logic               clipped;

    assign size_ok  = size_legal(blk_width) && size_legal(blk_height) &&
                      (int'(blk_width) <= MAX_BLK_SIZE) &&
                      (int'(blk_height) <= MAX_BLK_SIZE);
    assign start_ok = (state_q == ST_IDLE) && start && size_ok;
    assign area     = 14'(blk_width) * 14'(blk_height);

    // The output register frees up in the same cycle it is accepted, so a
    // consume can replace it with no bubble.
    assign in_ready   = (state_q == ST_RUN) && (!rec_valid || rec_ready);
    assign consume    = in_ready && res_valid && pred_valid;
    assign res_ready  = in_ready;
    assign pred_ready = in_ready;
    assign last_pair  = (cnt_q == term_q);

    assign busy = (state_q != ST_IDLE);
    assign done = (state_q == ST_DRAIN) && rec_valid && rec_ready;

    av2_clip_pixel #(
        .BIT_DEPTH(BIT_DEPTH)
    ) u_clip (
        .res    (res_data),
        .pred   (pred_data),
        .pix    (pix),
        .clipped(clipped)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (start_ok) state_d = ST_RUN;
            ST_RUN:   if (consume && last_pair) state_d = ST_DRAIN;
            ST_DRAIN: if (rec_valid && rec_ready) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; reset is synchronous, so it lives inside the clocked branch.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            term_q    <= '0;
            rec_valid <= 1'b0;
            rec_data  <= '0;
            rec_last  <= 1'b0;
            size_err  <= 1'b0;
        end else begin
            state_q  <= state_d;
            size_err <= (state_q == ST_IDLE) && start && !size_ok;

            if (start_ok) begin
                cnt_q  <= '0;
                term_q <= CNT_W'(area - 14'd1);
            end else if (consume) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end

            if (consume) begin
                rec_valid <= 1'b1;
                rec_data  <= pix;
                rec_last  <= last_pair;
            end else if (rec_ready) begin
                rec_valid <= 1'b0;
                rec_last  <= 1'b0;
            end
        end
    end

`ifdef AV2_RECON_CLIP_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            clip_count <= '0;
        end else if (start_ok) begin
            clip_count <= '0;
        end else if (consume && clipped) begin
            clip_count <= clip_count + CLIP_CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_av2_recon_add.sv
// Directed self-checking bench for av2_recon_add (BIT_DEPTH=10); checks
// clip_count as well when AV2_RECON_CLIP_CNT_EN is defined.
module tb_av2_recon_add;

    localparam int BD = 10;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [6:0]    blk_width;
    logic [6:0]    blk_height;
    logic          res_valid;
    logic          res_ready;
    logic signed [15:0] res_data;
    logic          pred_valid;
    logic          pred_ready;
    logic [BD-1:0] pred_data;
    logic          rec_valid;
    logic          rec_ready;
    logic [BD-1:0] rec_data;
    logic          rec_last;
    logic          busy;
    logic          done;
    logic          size_err;
`ifdef AV2_RECON_CLIP_CNT_EN
    logic [12:0]   clip_count;
`endif

    int errors = 0;
    int checks = 0;

    int res_arr[4096];
    int pred_arr[4096];
    int exp_arr[4096];

    av2_recon_add #(
        .BIT_DEPTH(BD),
        .MAX_BLK_SIZE(64)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .blk_width (blk_width),
        .blk_height(blk_height),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .pred_valid(pred_valid),
        .pred_ready(pred_ready),
        .pred_data (pred_data),
        .rec_valid (rec_valid),
        .rec_ready (rec_ready),
        .rec_data  (rec_data),
        .rec_last  (rec_last),
        .busy      (busy),
        .done      (done),
        .size_err  (size_err)
`ifdef AV2_RECON_CLIP_CNT_EN
        ,
        .clip_count(clip_count)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int clip_model(input int r, input int p);
        int s;
        s = r + p;
        if (s < 0) return 0;
        if (s > 1023) return 1023;
        return s;
    endfunction

    task automatic check_reset_outputs(input string tag);
        checks++; if (rec_valid !== 1'b0) begin errors++; $display("FAIL %s rec_valid: got %b want 0", tag, rec_valid); end
        checks++; if (rec_last !== 1'b0) begin errors++; $display("FAIL %s rec_last: got %b want 0", tag, rec_last); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL %s done: got %b want 0", tag, done); end
        checks++; if (size_err !== 1'b0) begin errors++; $display("FAIL %s size_err: got %b want 0", tag, size_err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL %s busy: got %b want 0", tag, busy); end
        checks++; if (res_ready !== 1'b0) begin errors++; $display("FAIL %s res_ready: got %b want 0", tag, res_ready); end
        checks++; if (pred_ready !== 1'b0) begin errors++; $display("FAIL %s pred_ready: got %b want 0", tag, pred_ready); end
        checks++; if (rec_data !== '0) begin errors++; $display("FAIL %s rec_data: got %0d want 0", tag, rec_data); end
    endtask

    // Runs one block from a start pulse to the final acceptance, checking every
    // output sample against exp_arr, handshake rules, done and busy.
    task automatic run_block(input int w, input int h, input bit ready_toggle,
                             input int pred_hold, input bit busy_start,
                             input string tag, output int cycles);
        int n, in_idx, out_idx, cyc, done_cnt, bad_done, serr_cnt, bad_busy, bad_rdy;
        bit stalled, prev_last;
        logic [BD-1:0] prev_data, exp_d;
        bit accept;
        n = w * h;
        in_idx = 0; out_idx = 0; cyc = 0;
        done_cnt = 0; bad_done = 0; serr_cnt = 0; bad_busy = 0; bad_rdy = 0;
        stalled = 1'b0; prev_last = 1'b0; prev_data = '0;

        @(negedge clk);
        blk_width = 7'(w); blk_height = 7'(h); start = 1'b1;
        @(negedge clk);
        start = 1'b0;

        while (out_idx < n && cyc < 20 * n + 50) begin
            start = busy_start && (cyc == 1);
            if (start) blk_width = 7'd12;
            rec_ready  = ready_toggle ? (cyc % 2 == 1) : 1'b1;
            res_valid  = (in_idx < n);
            pred_valid = (in_idx < n) && (cyc >= pred_hold);
            res_data   = (in_idx < n) ? 16'(res_arr[in_idx]) : '0;
            pred_data  = (in_idx < n) ? BD'(pred_arr[in_idx]) : '0;
            #1;
            if (cyc < pred_hold) begin
                checks++;
                if (res_ready !== 1'b1 || pred_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL %s ready_while_waiting cyc %0d: got res_ready=%b pred_ready=%b want 1/1",
                             tag, cyc, res_ready, pred_ready);
                end
            end
            if (pred_hold > 0 && cyc <= pred_hold) begin
                checks++;
                if (rec_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL %s no_consume cyc %0d: got rec_valid=%b want 0", tag, cyc, rec_valid);
                end
            end
            if (stalled) begin
                checks++;
                if (rec_valid !== 1'b1 || rec_data !== prev_data || rec_last !== prev_last) begin
                    errors++;
                    $display("FAIL %s stall_hold cyc %0d: got valid=%b data=%0d last=%b want 1/%0d/%b",
                             tag, cyc, rec_valid, rec_data, rec_last, prev_data, prev_last);
                end
            end
            if (res_ready !== pred_ready) bad_rdy++;
            accept = (rec_valid === 1'b1) && rec_ready;
            if (accept) begin
                exp_d = BD'(exp_arr[out_idx]);
                checks++;
                if (rec_data !== exp_d) begin
                    errors++;
                    $display("FAIL %s rec_data[%0d]: got %0d want %0d", tag, out_idx, rec_data, exp_d);
                end
                checks++;
                if (rec_last !== (out_idx == n - 1)) begin
                    errors++;
                    $display("FAIL %s rec_last[%0d]: got %b want %b", tag, out_idx, rec_last, out_idx == n - 1);
                end
            end
            if (done === 1'b1) begin
                done_cnt++;
                if (!(accept && out_idx == n - 1)) bad_done++;
            end
            if (size_err !== 1'b0) serr_cnt++;
            if (busy !== 1'b1) bad_busy++;
            if (res_valid && pred_valid && res_ready === 1'b1 && pred_ready === 1'b1) in_idx++;
            if (accept) out_idx++;
            stalled   = (rec_valid === 1'b1) && !rec_ready;
            prev_data = rec_data;
            prev_last = rec_last;
            @(negedge clk);
            cyc++;
        end
        start = 1'b0; res_valid = 1'b0; pred_valid = 1'b0; rec_ready = 1'b0;
        cycles = cyc;

        checks++;
        if (out_idx != n || in_idx != n) begin
            errors++;
            $display("FAIL %s sample_count: got in=%0d out=%0d want %0d", tag, in_idx, out_idx, n);
        end
        checks++;
        if (done_cnt != 1 || bad_done != 0) begin
            errors++;
            $display("FAIL %s done_pulse: got %0d pulses (%0d misplaced) want 1", tag, done_cnt, bad_done);
        end
        checks++;
        if (serr_cnt != 0) begin
            errors++;
            $display("FAIL %s size_err_while_busy: got %0d pulses want 0", tag, serr_cnt);
        end
        checks++;
        if (bad_busy != 0 || bad_rdy != 0) begin
            errors++;
            $display("FAIL %s busy_ready: got %0d busy-low and %0d ready-split cycles want 0", tag, bad_busy, bad_rdy);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s busy_after_done: got %b want 0", tag, busy);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; blk_width = 7'd4; blk_height = 7'd4;
        res_valid = 1'b1; pred_valid = 1'b1; res_data = 16'sd5; pred_data = 10'd100;
        rec_ready = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1; res_valid = 1'b0; pred_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic_4x4();
        int cycles;
        for (int i = 0; i < 16; i++) begin
            res_arr[i] = 5; pred_arr[i] = 100; exp_arr[i] = 105;
        end
        run_block(4, 4, 1'b0, 0, 1'b0, "basic4x4", cycles);
        checks++;
        if (cycles != 17) begin
            errors++;
            $display("FAIL basic4x4 throughput: got %0d cycles want 17", cycles);
        end
    endtask

    task automatic test_clip();
        int cycles;
        res_arr[0] = -300; pred_arr[0] = 100; exp_arr[0] = 0;
        res_arr[1] = 1000; pred_arr[1] = 100; exp_arr[1] = 1023;
        res_arr[2] = 923;  pred_arr[2] = 100; exp_arr[2] = 1023;
        res_arr[3] = -100; pred_arr[3] = 100; exp_arr[3] = 0;
        for (int i = 4; i < 16; i++) begin
            res_arr[i] = -7; pred_arr[i] = i * 10; exp_arr[i] = i * 10 - 7;
        end
        run_block(4, 4, 1'b0, 0, 1'b0, "clip", cycles);
`ifdef AV2_RECON_CLIP_CNT_EN
        checks++;
        if (clip_count !== 13'd2) begin
            errors++;
            $display("FAIL clip clip_count: got %0d want 2", clip_count);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (clip_count !== 13'd2) begin
            errors++;
            $display("FAIL clip clip_count_hold: got %0d want 2", clip_count);
        end
`endif
    endtask

    task automatic test_stall_8x8();
        int cycles;
        for (int i = 0; i < 64; i++) begin
            res_arr[i]  = i * 3 - 50;
            pred_arr[i] = i * 14 + 20;
            exp_arr[i]  = clip_model(res_arr[i], pred_arr[i]);
        end
        run_block(8, 8, 1'b1, 0, 1'b0, "stall8x8", cycles);
    endtask

    task automatic test_pred_wait();
        int cycles;
        for (int i = 0; i < 16; i++) begin
            res_arr[i] = i; pred_arr[i] = 200; exp_arr[i] = 200 + i;
        end
        run_block(4, 4, 1'b0, 3, 1'b0, "pred_wait", cycles);
    endtask

    task automatic test_size_err();
        int cycles;
        @(negedge clk);
        blk_width = 7'd12; blk_height = 7'd4; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (size_err !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL size_err_w12: got size_err=%b busy=%b want 1/0", size_err, busy);
        end
        @(negedge clk);
        checks++;
        if (size_err !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL size_err_pulse: got size_err=%b busy=%b want 0/0", size_err, busy);
        end
        blk_width = 7'd4; blk_height = 7'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (size_err !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL size_err_h5: got size_err=%b busy=%b want 1/0", size_err, busy);
        end
        for (int i = 0; i < 16; i++) begin
            res_arr[i] = 1; pred_arr[i] = 2; exp_arr[i] = 3;
        end
        run_block(4, 4, 1'b0, 0, 1'b1, "start_busy", cycles);
    endtask

    task automatic test_reset_mid();
        int consumed, cyc, cycles;
        @(negedge clk);
        blk_width = 7'd16; blk_height = 7'd16; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        consumed = 0; cyc = 0;
        rec_ready = 1'b1; res_valid = 1'b1; pred_valid = 1'b1;
        while (consumed < 10 && cyc < 100) begin
            res_data = 16'(consumed); pred_data = 10'd0;
            #1;
            if (res_ready === 1'b1 && pred_ready === 1'b1) consumed++;
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (consumed != 10 || busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid pre_reset: got %0d consumed busy=%b want 10/1", consumed, busy);
        end
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_outputs("reset_mid");
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || res_ready !== 1'b0 || rec_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid no_resume: got busy=%b res_ready=%b rec_valid=%b want 0/0/0",
                     busy, res_ready, rec_valid);
        end
        res_valid = 1'b0; pred_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            res_arr[i] = -i; pred_arr[i] = 50; exp_arr[i] = 50 - i;
        end
        run_block(4, 4, 1'b0, 0, 1'b0, "after_reset", cycles);
    endtask

    initial begin
        test_reset();
        test_basic_4x4();
        test_clip();
        test_stall_8x8();
        test_pred_wait();
        test_size_err();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/av2_recon_add.md
AV2_RECON_ADD -- requirements
Module: av2_recon_add

Interface
REQ-001 Parameter BIT_DEPTH, default 10, output pixel bit depth (8..12).
REQ-002 Parameter MAX_BLK_SIZE, default 64, largest block edge in samples.
REQ-003 clk  input  1  single clock; all logic on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous and active-low.
REQ-005 start  input  1  one-cycle pulse; begins one block; sampled only in IDLE.
REQ-006 blk_width  input  7  block width in samples, legal values 4/8/16/32/64; captured on start.
REQ-007 blk_height  input  7  block height in samples, same legal set; captured on start.
REQ-008 res_valid / res_ready  input / output  1 / 1  handshake for the residual stream from the inverse transform.
REQ-009 res_data  input  16 signed  residual sample, raster order.
REQ-010 pred_valid / pred_ready  input / output  1 / 1  handshake for the prediction stream.
REQ-011 pred_data  input  BIT_DEPTH unsigned  prediction sample, raster order.
REQ-012 rec_valid / rec_ready  output / input  1 / 1  handshake for reconstructed output.
REQ-013 rec_data  output  BIT_DEPTH unsigned  reconstructed sample.
REQ-014 rec_last  output  1  high with the final sample of the block.
REQ-015 busy  output  1  high outside IDLE.
REQ-016 done  output  1  one-cycle pulse at block completion.
REQ-017 size_err  output  1  one-cycle pulse when start arrives with an illegal size.

Function
REQ-018 The FSM SHALL have the states IDLE, RUN and DRAIN.
- IDLE->RUN: start with legal sizes; capture the sizes and clear the sample counter.
- RUN->DRAIN: on the cycle the last pair is consumed.
- DRAIN->IDLE: when the last output is accepted; done pulses that same cycle.
REQ-019 Start with an illegal width or height SHALL pulse size_err the next cycle and leave the FSM in IDLE.
REQ-020 Start seen outside IDLE SHALL be ignored, with no size_err.
REQ-021 A pair SHALL be consumed only when all of the following hold:
- the FSM is in RUN;
- res_valid and pred_valid are both high;
- the output register is empty, or rec_ready is high.
REQ-022 res_ready and pred_ready SHALL both equal the consume condition of REQ-021 excluding the input valids, so the two streams are always consumed together.
REQ-023 Arithmetic SHALL be as follows:
- form the sum sign-extended res_data (18 bit) + zero-extended pred_data;
- clip the sum to [0, 2^BIT_DEPTH-1];
- a negative sum gives 0; a sum above the maximum gives 2^BIT_DEPTH-1.
REQ-024 Latency SHALL be one cycle from consume to rec_valid, through a single output register.
REQ-025 While rec_valid is high and rec_ready is low, rec_data and rec_last SHALL hold stable.
REQ-026 At full throughput the block SHALL sustain one sample per cycle.
REQ-027 The sample counter SHALL count to blk_width*blk_height-1; rec_last SHALL be set on the sample whose count equals that terminal value.
REQ-028 If rec_ready is high in the same cycle as a new consume, the register SHALL be replaced by the new sample with no bubble.

Reset
REQ-029 With rst_n low at a clock edge, the block SHALL enter IDLE, with the following outputs low:
- rec_valid, rec_last, done, size_err, busy, res_ready, pred_ready;
- rec_data = 0.
REQ-030 A reset mid-block SHALL discard the block; after reset, only a new start resumes operation.

Configuration
REQ-031 With AV2_RECON_CLIP_CNT_EN defined, the block SHALL behave as follows:
- it adds output clip_count (13 bit);
- the count is cleared on start and increments on each consumed sample whose sum was clipped;
- the count holds after done until the next start.
REQ-032 Without AV2_RECON_CLIP_CNT_EN, the port and its counter SHALL be absent, with all other behaviour identical.

Structure
REQ-033 The shared package av2_recon_pkg SHALL hold:
- the FSM state enum;
- the legal block-size constants;
- the function that checks size legality.
REQ-034 The sub-module av2_clip_pixel SHALL hold the combinational add-and-clip; it is parameterised by BIT_DEPTH and outputs a clipped flag.

Verification
REQ-035 4x4 block, BIT_DEPTH=10, res=5, pred=100, rec_ready held high: expect 16 outputs equal to 105, rec_last on the 16th, done with the final acceptance, one sample per cycle.
REQ-036 res=-300 with pred=100, then res=1000 with pred=100: expect 0 then 1023; with the macro defined, clip_count=2.
REQ-037 8x8 block with rec_ready toggled every other cycle: expect rec_data stable while stalled, no sample lost or duplicated, 64 outputs.
REQ-038 res_valid high with pred_valid low for 3 cycles: expect no consume and both readies asserted; the pair is consumed when pred_valid rises.
REQ-039 Start with blk_width=12: expect a size_err pulse and busy to stay low; a start while busy is ignored.
REQ-040 Reset asserted after 10 samples of a 16x16 block: expect all outputs at reset values next cycle; a following 4x4 block completes correctly.
